// File: rtl/raster_pkg.sv
// Shared raster front-end types, screen defaults and three-way min/max helpers.
package raster_pkg;

    localparam int SCREEN_W_DEF = 320;
    localparam int SCREEN_H_DEF = 240;
    localparam int MC_W         = 32;

    typedef enum logic [1:0] {
        CULL_NONE = 2'd0,
        CULL_CW   = 2'd1,
        CULL_CCW  = 2'd2
    } cull_mode_e;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DECIDE,
        EMIT
    } setup_state_e;

    function automatic logic signed [MC_W-1:0] min3(input logic signed [MC_W-1:0] a,
                                                     input logic signed [MC_W-1:0] b,
                                                     input logic signed [MC_W-1:0] c);
        logic signed [MC_W-1:0] m;
        m = (a < b) ? a : b;
        return (c < m) ? c : m;
    endfunction

    function automatic logic signed [MC_W-1:0] max3(input logic signed [MC_W-1:0] a,
                                                     input logic signed [MC_W-1:0] b,
                                                     input logic signed [MC_W-1:0] c);
        logic signed [MC_W-1:0] m;
        m = (a > b) ? a : b;
        return (c > m) ? c : m;
    endfunction

endpackage

// File: rtl/tri_fifo.sv
// Synchronous FIFO with registered full/empty flags; read data is registered on pop
// and holds until the next pop.
module tri_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic             do_push;
    logic             do_pop;

    assign do_push = i_push && !o_full;
    assign do_pop  = i_pop && !o_empty;

    always_ff @(posedge i_clk) begin
        if (do_push)
            mem[wptr] <= i_data;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wptr    <= '0;
            rptr    <= '0;
            o_full  <= 1'b0;
            o_empty <= 1'b1;
            o_data  <= '0;
        end else begin
            if (do_push)
                wptr <= wptr + 1'b1;
            if (do_pop) begin
                rptr   <= rptr + 1'b1;
                o_data <= mem[rptr];
            end
            // Flags only move when occupancy changes; a simultaneous push+pop keeps them.
            if (do_push && !do_pop) begin
                o_empty <= 1'b0;
                o_full  <= (AW'(wptr + 1'b1) == rptr);
            end else if (do_pop && !do_push) begin
                o_full  <= 1'b0;
                o_empty <= (AW'(rptr + 1'b1) == wptr);
            end
        end
    end

endmodule

// File: rtl/tri_setup_queue.sv
// Triangle setup front-end: queues triangles, computes doubled signed area and a clamped
// bounding box, culls degenerate/back-facing/off-screen ones and emits the rest.
module tri_setup_queue
    import raster_pkg::*;
#(
    parameter int SCREEN_W  = SCREEN_W_DEF,
    parameter int SCREEN_H  = SCREEN_H_DEF,
    parameter int COORD_W   = 16,
    parameter int Z_W       = 8,
    parameter int UV_W      = 32,
    parameter int DEPTH     = 4,
    parameter int CULL_MODE = 0,
    parameter int STAT_W    = 16
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_tri_valid,
    output logic                      o_tri_ready,
    input  logic [6*COORD_W-1:0]      i_tri_xy,
    input  logic [3*Z_W-1:0]          i_tri_z,
    input  logic [6*UV_W-1:0]         i_tri_uv,
    output logic                      o_out_valid,
    input  logic                      i_out_ready,
    output logic [6*COORD_W-1:0]      o_out_xy,
    output logic [3*Z_W-1:0]          o_out_z,
    output logic [6*UV_W-1:0]         o_out_uv,
    output logic [COORD_W-1:0]        o_min_x,
    output logic [COORD_W-1:0]        o_max_x,
    output logic [COORD_W-1:0]        o_min_y,
    output logic [COORD_W-1:0]        o_max_y,
    output logic [2*COORD_W+1:0]      o_area,
    output logic                      o_idle,
    input  logic                      i_clr_stats,
    output logic [STAT_W-1:0]         o_cnt_in,
    output logic [STAT_W-1:0]         o_cnt_emit,
    output logic [STAT_W-1:0]         o_cnt_cull
);
    localparam int XY_W   = 6*COORD_W;
    localparam int ZS_W   = 3*Z_W;
    localparam int UVS_W  = 6*UV_W;
    localparam int ENT_W  = XY_W + ZS_W + UVS_W;
    localparam int AREA_W = 2*COORD_W + 2;

    localparam logic signed [COORD_W-1:0] X_MAX = COORD_W'(SCREEN_W - 1);
    localparam logic signed [COORD_W-1:0] Y_MAX = COORD_W'(SCREEN_H - 1);

    setup_state_e state;

    logic                fifo_full;
    logic                fifo_empty;
    logic                fifo_pop;
    logic                push;
    logic [ENT_W-1:0]    fifo_q;
    logic [XY_W-1:0]     q_xy;
    logic [ZS_W-1:0]     q_z;
    logic [UVS_W-1:0]    q_uv;

    logic signed [COORD_W-1:0] vx [3];
    logic signed [COORD_W-1:0] vy [3];
    logic signed [AREA_W-1:0]  ex [3];
    logic signed [AREA_W-1:0]  ey [3];
    logic signed [AREA_W-1:0]  area_next;

    logic signed [AREA_W-1:0]  area_r;
    logic signed [COORD_W-1:0] rmin_x, rmax_x, rmin_y, rmax_y;
    logic                      cull;
    logic                      emit_hs;

    assign o_tri_ready = !fifo_full;
    assign push        = i_tri_valid && !fifo_full;
    assign fifo_pop    = (state == IDLE) && !fifo_empty;
    assign emit_hs     = (state == EMIT) && o_out_valid && i_out_ready;
    assign o_idle      = fifo_empty && (state == IDLE) && !o_out_valid;

    tri_fifo #(
        .WIDTH (ENT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_push  (push),
        .i_data  ({i_tri_uv, i_tri_z, i_tri_xy}),
        .i_pop   (fifo_pop),
        .o_data  (fifo_q),
        .o_full  (fifo_full),
        .o_empty (fifo_empty)
    );

    assign q_xy = fifo_q[XY_W-1:0];
    assign q_z  = fifo_q[XY_W +: ZS_W];
    assign q_uv = fifo_q[XY_W+ZS_W +: UVS_W];

    // Operands are widened before subtracting so the products cannot overflow.
    always_comb begin
        for (int k = 0; k < 3; k++) begin
            vx[k] = q_xy[2*k*COORD_W +: COORD_W];
            vy[k] = q_xy[(2*k+1)*COORD_W +: COORD_W];
            ex[k] = AREA_W'(vx[k]);
            ey[k] = AREA_W'(vy[k]);
        end
        area_next = (ex[2] - ex[0]) * (ey[1] - ey[0]) - (ex[1] - ex[0]) * (ey[2] - ey[0]);
    end

    always_comb begin
        cull = (area_r == '0);
        if (CULL_MODE == int'(CULL_CW) && area_r[AREA_W-1])
            cull = 1'b1;
        if (CULL_MODE == int'(CULL_CCW) && !area_r[AREA_W-1] && area_r != '0)
            cull = 1'b1;
        if (rmax_x[COORD_W-1] || rmin_x > X_MAX || rmax_y[COORD_W-1] || rmin_y > Y_MAX)
            cull = 1'b1;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state       <= IDLE;
            o_out_valid <= 1'b0;
            o_out_xy    <= '0;
            o_out_z     <= '0;
            o_out_uv    <= '0;
            o_min_x     <= '0;
            o_max_x     <= '0;
            o_min_y     <= '0;
            o_max_y     <= '0;
            o_area      <= '0;
            area_r      <= '0;
            rmin_x      <= '0;
            rmax_x      <= '0;
            rmin_y      <= '0;
            rmax_y      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (!fifo_empty)
                        state <= CALC;
                end
                CALC: begin
                    area_r <= area_next;
                    rmin_x <= COORD_W'(min3(MC_W'(vx[0]), MC_W'(vx[1]), MC_W'(vx[2])));
                    rmax_x <= COORD_W'(max3(MC_W'(vx[0]), MC_W'(vx[1]), MC_W'(vx[2])));
                    rmin_y <= COORD_W'(min3(MC_W'(vy[0]), MC_W'(vy[1]), MC_W'(vy[2])));
                    rmax_y <= COORD_W'(max3(MC_W'(vy[0]), MC_W'(vy[1]), MC_W'(vy[2])));
                    state  <= DECIDE;
                end
                DECIDE: begin
                    if (cull) begin
                        state <= IDLE;
                    end else begin
                        // Survivors overlap the screen, so only the outward edges need clamping.
                        o_min_x     <= rmin_x[COORD_W-1] ? '0 : rmin_x;
                        o_max_x     <= (rmax_x > X_MAX) ? X_MAX : rmax_x;
                        o_min_y     <= rmin_y[COORD_W-1] ? '0 : rmin_y;
                        o_max_y     <= (rmax_y > Y_MAX) ? Y_MAX : rmax_y;
                        o_area      <= area_r;
                        o_out_xy    <= q_xy;
                        o_out_z     <= q_z;
                        o_out_uv    <= q_uv;
                        o_out_valid <= 1'b1;
                        state       <= EMIT;
                    end
                end
                EMIT: begin
                    if (i_out_ready) begin
                        o_out_valid <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr_stats) begin
            o_cnt_in   <= '0;
            o_cnt_emit <= '0;
            o_cnt_cull <= '0;
        end else begin
            if (push)
                o_cnt_in <= o_cnt_in + 1'b1;
            if (emit_hs)
                o_cnt_emit <= o_cnt_emit + 1'b1;
            if (state == DECIDE && cull)
                o_cnt_cull <= o_cnt_cull + 1'b1;
        end
    end

endmodule

// File: tb/tb_tri_setup_queue.sv
// Scoreboard bench: three instances (CULL_MODE 0/1/2) share stimulus; each has its own
// expected-result queue fed by a reference model at push time.
module tb_tri_setup_queue;
    localparam int CW   = 16;
    localparam int XYW  = 6*CW;
    localparam int ZZW  = 24;
    localparam int UVVW = 192;
    localparam int AW   = 2*CW + 2;
    localparam int SW   = 16;

    logic i_clk = 1'b0;
    logic i_rst, i_tri_valid, i_out_ready, i_clr_stats;
    logic [XYW-1:0]  i_tri_xy;
    logic [ZZW-1:0]  i_tri_z;
    logic [UVVW-1:0] i_tri_uv;

    logic [2:0]           tri_ready, out_valid, idle;
    logic [2:0][XYW-1:0]  out_xy;
    logic [2:0][ZZW-1:0]  out_z;
    logic [2:0][UVVW-1:0] out_uv;
    logic [2:0][CW-1:0]   min_x, max_x, min_y, max_y;
    logic [2:0][AW-1:0]   area;
    logic [2:0][SW-1:0]   cnt_in, cnt_emit, cnt_cull;

    always #5 i_clk = ~i_clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        tri_setup_queue #(.CULL_MODE(g)) u_dut (
            .i_clk       (i_clk),
            .i_rst       (i_rst),
            .i_tri_valid (i_tri_valid),
            .o_tri_ready (tri_ready[g]),
            .i_tri_xy    (i_tri_xy),
            .i_tri_z     (i_tri_z),
            .i_tri_uv    (i_tri_uv),
            .o_out_valid (out_valid[g]),
            .i_out_ready (i_out_ready),
            .o_out_xy    (out_xy[g]),
            .o_out_z     (out_z[g]),
            .o_out_uv    (out_uv[g]),
            .o_min_x     (min_x[g]),
            .o_max_x     (max_x[g]),
            .o_min_y     (min_y[g]),
            .o_max_y     (max_y[g]),
            .o_area      (area[g]),
            .o_idle      (idle[g]),
            .i_clr_stats (i_clr_stats),
            .o_cnt_in    (cnt_in[g]),
            .o_cnt_emit  (cnt_emit[g]),
            .o_cnt_cull  (cnt_cull[g])
        );
    end

    typedef struct packed {
        logic [AW-1:0]   area;
        logic [CW-1:0]   min_x, max_x, min_y, max_y;
        logic [XYW-1:0]  xy;
        logic [ZZW-1:0]  z;
        logic [UVVW-1:0] uv;
    } exp_t;

    exp_t q0[$], q1[$], q2[$];
    int   exp_in[3], exp_emit[3], exp_cull[3];
    int   n_vec = 0, n_err = 0;

    task automatic chk(input string tag, input logic [511:0] act, input logic [511:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, act, exp);
        end
    endtask

    function automatic exp_t model(input logic [XYW-1:0] xy, input logic [ZZW-1:0] z,
                                   input logic [UVVW-1:0] uv, input int mode, output bit kept);
        exp_t   e;
        longint x[3], y[3], a, mnx, mxx, mny, mxy;
        for (int k = 0; k < 3; k++) begin
            x[k] = longint'($signed(xy[2*k*CW +: CW]));
            y[k] = longint'($signed(xy[(2*k+1)*CW +: CW]));
        end
        a = (x[2]-x[0])*(y[1]-y[0]) - (x[1]-x[0])*(y[2]-y[0]);
        mnx = x[0]; mxx = x[0]; mny = y[0]; mxy = y[0];
        for (int k = 1; k < 3; k++) begin
            if (x[k] < mnx) mnx = x[k];
            if (x[k] > mxx) mxx = x[k];
            if (y[k] < mny) mny = y[k];
            if (y[k] > mxy) mxy = y[k];
        end
        kept = !(a == 0 || (mode == 1 && a < 0) || (mode == 2 && a > 0) ||
                 mxx < 0 || mnx > 319 || mxy < 0 || mny > 239);
        e.area  = a[AW-1:0];
        e.min_x = CW'((mnx < 0) ? 64'sd0 : mnx);
        e.max_x = CW'((mxx > 319) ? 64'sd319 : mxx);
        e.min_y = CW'((mny < 0) ? 64'sd0 : mny);
        e.max_y = CW'((mxy > 239) ? 64'sd239 : mxy);
        e.xy = xy; e.z = z; e.uv = uv;
        return e;
    endfunction

    task automatic sb_push(input int m, input exp_t e);
        case (m)
            0: q0.push_back(e);
            1: q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endtask

    task automatic sb_pop(input int m);
        exp_t e;
        int   sz;
        sz = (m == 0) ? q0.size() : (m == 1) ? q1.size() : q2.size();
        if (sz == 0) begin
            chk($sformatf("spurious_out_m%0d", m), out_valid[m], 1'b0);
            return;
        end
        case (m)
            0: e = q0.pop_front();
            1: e = q1.pop_front();
            default: e = q2.pop_front();
        endcase
        chk($sformatf("area_m%0d", m), area[m], e.area);
        chk($sformatf("box_m%0d", m), {min_x[m], max_x[m], min_y[m], max_y[m]},
            {e.min_x, e.max_x, e.min_y, e.max_y});
        chk($sformatf("data_m%0d", m), {out_xy[m], out_z[m], out_uv[m]}, {e.xy, e.z, e.uv});
    endtask

    task automatic mon(input int m);
        exp_t e;
        bit   k;
        if (out_valid[m] && i_out_ready) begin
            sb_pop(m);
            if (!i_clr_stats) exp_emit[m]++;
        end
        if (i_tri_valid && tri_ready[m]) begin
            e = model(i_tri_xy, i_tri_z, i_tri_uv, m, k);
            if (!i_clr_stats) exp_in[m]++;
            if (k) sb_push(m, e);
            else if (!i_clr_stats) exp_cull[m]++;
        end
    endtask

    // Inputs change just after posedge, so the negedge sees exactly what the next edge will.
    always @(negedge i_clk) begin
        if (i_rst) begin
            q0.delete(); q1.delete(); q2.delete();
            for (int m = 0; m < 3; m++) begin
                exp_in[m] = 0; exp_emit[m] = 0; exp_cull[m] = 0;
            end
        end else begin
            for (int m = 0; m < 3; m++) mon(m);
            if (i_clr_stats)
                for (int m = 0; m < 3; m++) begin
                    exp_in[m] = 0; exp_emit[m] = 0; exp_cull[m] = 0;
                end
        end
    end

    task automatic set_tri(input int x0, y0, x1, y1, x2, y2);
        i_tri_xy = {CW'(y2), CW'(x2), CW'(y1), CW'(x1), CW'(y0), CW'(x0)};
        i_tri_z  = ZZW'($urandom);
        i_tri_uv = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic push1(input int x0, y0, x1, y1, x2, y2);
        set_tri(x0, y0, x1, y1, x2, y2);
        i_tri_valid = 1'b1;
        tick();
        i_tri_valid = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (idle != 3'b111 && n < budget) begin
            tick();
            n++;
        end
        if (idle != 3'b111) chk("idle_timeout", idle, 3'b111);
    endtask

    task automatic chk_cnt(input string tag);
        for (int m = 0; m < 3; m++) begin
            chk($sformatf("%s_in_m%0d", tag, m), cnt_in[m], SW'(exp_in[m]));
            chk($sformatf("%s_emit_m%0d", tag, m), cnt_emit[m], SW'(exp_emit[m]));
            chk($sformatf("%s_cull_m%0d", tag, m), cnt_cull[m], SW'(exp_cull[m]));
        end
    endtask

    initial begin
        int n;
        i_rst = 1'b1; i_tri_valid = 1'b0; i_out_ready = 1'b1; i_clr_stats = 1'b0;
        i_tri_xy = '0; i_tri_z = '0; i_tri_uv = '0;
        repeat (3) tick();
        i_rst = 1'b0;

        for (int m = 0; m < 3; m++) begin
            chk($sformatf("rst_valid_m%0d", m), out_valid[m], 1'b0);
            chk($sformatf("rst_idle_m%0d", m), idle[m], 1'b1);
            chk($sformatf("rst_ready_m%0d", m), tri_ready[m], 1'b1);
            chk($sformatf("rst_cnt_m%0d", m), {cnt_in[m], cnt_emit[m], cnt_cull[m]}, 48'd0);
            chk($sformatf("rst_out_m%0d", m), {area[m], min_x[m], max_x[m], out_xy[m]}, '0);
        end

        // CW triangle: latency from push to valid, kept in mode 0/2, culled in mode 1
        set_tri(10, 10, 50, 10, 10, 40);
        i_tri_valid = 1'b1;
        tick();
        i_tri_valid = 1'b0;
        n = 1;
        while (!out_valid[0] && n < 20) begin
            tick();
            n++;
        end
        chk("latency", n, 4);
        chk("cw_area", area[0], 34'h3_FFFF_FB50);
        wait_idle(50);
        chk_cnt("t1");
        chk("m1_cull_cw", cnt_cull[1], 16'd1);

        push1(10, 10, 10, 40, 50, 10);
        wait_idle(50);
        chk_cnt("t2");
        chk("m1_emit_ccw", cnt_emit[1], 16'd1);

        push1(-20, -5, 400, 100, 30, 300);
        push1(320, 0, 400, 10, 330, 50);
        push1(319, 0, 330, 10, 319, 50);
        push1(0, 0, 10, 10, 20, 20);
        wait_idle(100);
        chk_cnt("t3");

        for (int c = 0; c < 80; c++) begin
            set_tri(int'($urandom_range(0, 440)) - 60, int'($urandom_range(0, 360)) - 60,
                    int'($urandom_range(0, 440)) - 60, int'($urandom_range(0, 360)) - 60,
                    int'($urandom_range(0, 440)) - 60, int'($urandom_range(0, 360)) - 60);
            i_tri_valid = 1'($urandom_range(0, 1));
            i_out_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        i_tri_valid = 1'b0;
        i_out_ready = 1'b1;
        wait_idle(300);
        chk_cnt("rand");

        i_clr_stats = 1'b1;
        tick();
        i_clr_stats = 1'b0;
        chk_cnt("clr");

        // Stall: 4 in FIFO plus 1 held in setup, sixth push refused
        i_out_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            set_tri(10 + 5*i, 10, 50, 10 + i, 10, 40);
            i_tri_valid = 1'b1;
            tick();
        end
        i_tri_valid = 1'b0;
        chk("full_ready", tri_ready[0], 1'b0);
        chk("accepted", cnt_in[0], 16'd5);
        for (int i = 0; i < 3; i++) begin
            tick();
            if (q0.size() == 0) chk("stall_head", q0.size(), 1);
            else begin
                chk("stall_valid", out_valid[0], 1'b1);
                chk("stall_area", area[0], q0[0].area);
                chk("stall_xy", out_xy[0], q0[0].xy);
            end
        end
        i_out_ready = 1'b1;
        wait_idle(200);
        chk_cnt("stall");

        // Reset while emitting with two triangles still queued
        i_out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            set_tri(20, 20, 60, 20 + i, 20, 60);
            i_tri_valid = 1'b1;
            tick();
        end
        i_tri_valid = 1'b0;
        n = 0;
        while (!out_valid[0] && n < 20) begin
            tick();
            n++;
        end
        if (!out_valid[0]) chk("emit_timeout", out_valid[0], 1'b1);
        i_rst = 1'b1;
        tick();
        i_rst = 1'b0;
        chk("post_rst_valid", out_valid[0], 1'b0);
        chk("post_rst_idle", idle[0], 1'b1);
        chk("post_rst_cnt", {cnt_in[0], cnt_emit[0], cnt_cull[0]}, 48'd0);
        i_out_ready = 1'b1;
        repeat (20) tick();
        chk_cnt("post_rst");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
